// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and helpers for the four-digit multiplexed display scanner.
package display_scan_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam logic [3:0] ANODES_OFF = 4'b1111;

    typedef struct packed {
        logic        lz_en;
        logic [3:0]  dots;
        logic [15:0] digits;
    } disp_data_t;

    function automatic logic [3:0] digit_sel(input logic [15:0] digits, input logic [1:0] idx);
        return digits[idx*4 +: 4];
    endfunction

    function automatic logic [3:0] anode_on(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_lz_mask.sv
// Leading-zero suppression mask: bit i set when digit i and every higher digit are zero.
module lz_mask
    import display_scan_ctrl_pkg::*;
(
    input  logic [15:0] i_digits,
    input  logic        i_lz_en,
    output logic [3:0]  o_suppress
);

    logic w_z3;
    logic w_z2;
    logic w_z1;

    assign w_z3 = (digit_sel(i_digits, 2'd3) == 4'd0);
    assign w_z2 = (digit_sel(i_digits, 2'd2) == 4'd0);
    assign w_z1 = (digit_sel(i_digits, 2'd1) == 4'd0);

    // Digit 0 always shows so a zero value still displays "0".
    assign o_suppress = {i_lz_en & w_z3,
                         i_lz_en & w_z3 & w_z2,
                         i_lz_en & w_z3 & w_z2 & w_z1,
                         1'b0};

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit 7-segment scan controller with blanking gaps, shadow/active
// double buffering applied only at frame boundaries, and leading-zero blanking.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int SHOW_CYC  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic [3:0]  dots,
    input  logic        lz_en,
    output logic [3:0]  digit_out,
    output logic        dot_out,
    output logic [3:0]  an,
    output logic        frame_start,
    output logic        pending
);

    localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    logic [1:0]    r_state;
    logic [1:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_arm;
    disp_data_t    r_active;
    disp_data_t    r_shadow;
    logic          r_pending;
    logic [3:0]    r_an;
    logic [3:0]    r_digit;
    logic          r_dot;
    logic          r_fs;

    logic [1:0]    w_state_nxt;
    logic [1:0]    w_idx_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_fs_nxt;
    logic          w_update;
    disp_data_t    w_active_nxt;
    disp_data_t    w_shadow_nxt;
    logic          w_pending_nxt;
    logic [3:0]    w_suppress;
    logic [3:0]    w_digit_nxt;
    logic          w_dot_nxt;
    logic [3:0]    w_an_nxt;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_fs_nxt    = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // r_arm holds off the first move until the second edge after reset.
                    if (r_arm) begin
                        w_state_nxt = ST_BLANK;
                        w_idx_nxt   = 2'd0;
                        w_cnt_nxt   = '0;
                        w_fs_nxt    = 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nxt = ST_SHOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = r_idx + 2'd1;
                        w_fs_nxt    = (r_idx == 2'd3);
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // The swap happens on the edge entering the frame_start cycle, so the whole
    // frame, including its first blanking slot, uses one consistent data set.
    assign w_update      = w_fs_nxt & r_pending;
    assign w_active_nxt  = w_update ? r_shadow : r_active;
    assign w_shadow_nxt  = load ? disp_data_t'{lz_en, dots, digits} : r_shadow;
    assign w_pending_nxt = load | (r_pending & ~w_update);

    lz_mask u_lz_mask (
        .i_digits   (w_active_nxt.digits),
        .i_lz_en    (w_active_nxt.lz_en),
        .o_suppress (w_suppress)
    );

    assign w_digit_nxt = digit_sel(w_active_nxt.digits, w_idx_nxt);
    assign w_dot_nxt   = w_active_nxt.dots[w_idx_nxt];

    always_comb begin
        w_an_nxt = ANODES_OFF;
        if (w_state_nxt == ST_SHOW && !(w_suppress[w_idx_nxt] && !w_dot_nxt))
            w_an_nxt = anode_on(w_idx_nxt);
    end

    // NOTE: sequential state uses non-blocking assignments only; the small
    // active/shadow registers are reset too because they feed visible outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= 2'd0;
            r_cnt     <= '0;
            r_arm     <= 1'b0;
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_an      <= ANODES_OFF;
            r_digit   <= 4'd0;
            r_dot     <= 1'b0;
            r_fs      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_arm     <= 1'b1;
            r_active  <= w_active_nxt;
            r_shadow  <= w_shadow_nxt;
            r_pending <= w_pending_nxt;
            r_an      <= w_an_nxt;
            r_digit   <= w_digit_nxt;
            r_dot     <= w_dot_nxt;
            r_fs      <= w_fs_nxt;
        end
    end

    assign an          = r_an;
    assign digit_out   = r_digit;
    assign dot_out     = r_dot;
    assign frame_start = r_fs;
    assign pending     = r_pending;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a frame-position reference model
// predicts every cycle's outputs and a separate monitor compares them.
module tb_display_scan_ctrl;

    localparam int S     = 4;
    localparam int B     = 1;
    localparam int SLOT  = B + S;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits = 16'h0;
    logic [3:0]  dots = 4'h0;
    logic        lz_en = 1'b0;
    logic [3:0]  digit_out;
    logic        dot_out;
    logic [3:0]  an;
    logic        frame_start;
    logic        pending;

    int n_checks = 0;
    int n_fail   = 0;

    display_scan_ctrl #(.SHOW_CYC(S), .BLANK_CYC(B)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .load        (load),
        .digits      (digits),
        .dots        (dots),
        .lz_en       (lz_en),
        .digit_out   (digit_out),
        .dot_out     (dot_out),
        .an          (an),
        .frame_start (frame_start),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] an;
        logic [3:0] digit;
        logic       dot;
        logic       fs;
        logic       pend;
        bit         on;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: frame position counted in cycles, data as plain variables.
    bit          m_on = 0;
    bit          m_arm = 0;
    int          m_t = 0;
    logic [15:0] a_dig = 0, s_dig = 0;
    logic [3:0]  a_dot = 0, s_dot = 0;
    logic        a_lz = 0, s_lz = 0;
    logic        m_pend = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_on = 0; m_arm = 0; m_t = 0;
            a_dig = 0; a_dot = 0; a_lz = 0;
            s_dig = 0; s_dot = 0; s_lz = 0;
            m_pend = 0;
            exp_q.delete();
        end else begin
            exp_t e;
            bit fs, upd, supp;
            int slot;
            logic [15:0] sh;
            if (!en) m_on = 0;
            else if (!m_on) begin
                if (m_arm) begin m_on = 1; m_t = 0; fs = 1; end
            end else m_t = (m_t + 1) % FRAME;
            fs  = m_on && (m_t == 0) && en;
            upd = fs && m_pend;
            if (upd) begin a_dig = s_dig; a_dot = s_dot; a_lz = s_lz; end
            m_pend = load || (m_pend && !upd);
            if (load) begin s_dig = digits; s_dot = dots; s_lz = lz_en; end
            m_arm = 1;

            slot = m_t / SLOT;
            sh   = a_dig >> (4 * slot);
            supp = 0;
            if (a_lz && slot > 0) begin
                supp = 1;
                for (int j = slot; j < 4; j++) begin
                    logic [15:0] hj;
                    hj = a_dig >> (4 * j);
                    if (hj[3:0] != 4'd0) supp = 0;
                end
            end
            e.on    = m_on;
            e.fs    = fs;
            e.pend  = m_pend;
            e.digit = sh[3:0];
            e.dot   = a_dot[slot];
            e.an    = 4'hF;
            if (m_on && (m_t % SLOT) >= B && !(supp && !e.dot))
                e.an = ~(4'b0001 << slot);
            exp_q.push_back(e);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("an", {12'h0, an}, {12'h0, e.an});
            check("frame_start", {15'h0, frame_start}, {15'h0, e.fs});
            check("pending", {15'h0, pending}, {15'h0, e.pend});
            check("one_anode_max", {15'h0, ($countones(~an) <= 1)}, 16'h1);
            if (e.on) begin
                check("digit_out", {12'h0, digit_out}, {12'h0, e.digit});
                check("dot_out", {15'h0, dot_out}, {15'h0, e.dot});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dt, input logic lz);
        digits = d; dots = dt; lz_en = lz; load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] pat, output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (an === pat) ok = 1;
        end
    endtask

    initial begin
        bit ok;
        tick(2);
        check("rst_an", {12'h0, an}, 16'h000F);
        check("rst_digit", {12'h0, digit_out}, 16'h0);
        check("rst_dot", {15'h0, dot_out}, 16'h0);
        check("rst_fs", {15'h0, frame_start}, 16'h0);
        check("rst_pending", {15'h0, pending}, 16'h0);
        rst_n = 1'b1;
        tick(2);

        // Scan order with 1234 and a dot on digit 2.
        do_load(16'h1234, 4'b0100, 1'b0);
        en = 1'b1;
        tick(3 * FRAME);

        // Mid-frame load applies only at the next frame boundary.
        tick(7);
        do_load(16'h5678, 4'b0000, 1'b0);
        tick(2 * FRAME);

        // Leading-zero blanking, then a dot forcing digit 3 on.
        do_load(16'h0040, 4'b0000, 1'b1);
        tick(2 * FRAME);
        do_load(16'h0040, 4'b1000, 1'b1);
        tick(2 * FRAME);

        // Drop enable during digit-2 SHOW, then re-enable.
        do_load(16'h1234, 4'b0000, 1'b0);
        tick(FRAME);
        wait_an(4'b1011, ok);
        check("wait_digit2_show", {15'h0, ok}, 16'h1);
        en = 1'b0;
        tick(4);
        en = 1'b1;
        tick(FRAME + 3);

        // Load collision on the update edge: 8888 shown, 9999 stays pending.
        en = 1'b0;
        do_load(16'h8888, 4'b0000, 1'b0);
        en = 1'b1;
        do_load(16'h9999, 4'b0000, 1'b0);
        tick(2 * FRAME);

        // Randomised traffic.
        for (int it = 0; it < 60; it++) begin
            logic [31:0] r;
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom >> (4 * $urandom_range(0, 4));
                do_load(r[15:0], 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
            tick($urandom_range(1, 25));
        end

        // Asynchronous reset mid-SHOW with shadow data pending.
        en = 1'b1;
        do_load(16'h4321, 4'b0000, 1'b0);
        tick(2 * FRAME);
        wait_an(4'b1101, ok);
        check("wait_digit1_show", {15'h0, ok}, 16'h1);
        do_load(16'hABCD, 4'b0000, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", {12'h0, an}, 16'h000F);
        check("async_rst_pending", {15'h0, pending}, 16'h0);
        check("async_rst_fs", {15'h0, frame_start}, 16'h0);
        tick(2);
        rst_n = 1'b1;
        tick(FRAME + 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
